// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 2R/1W register file with byte enables, zero register and background clear
module reg_file_param #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regwrite,
  input  logic [AW-1:0]     wra,
  input  logic [DW-1:0]     wd,
  input  logic [DW/8-1:0]   wbe,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic [DW-1:0]     rd1,
  output logic [DW-1:0]     rd2,
  input  logic              clr_req,
  output logic              busy
);

  localparam int DEPTH = 2**AW;
  localparam int NB    = DW/8;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   merged;
  logic [DW-1:0]   rd1_n;
  logic [DW-1:0]   rd2_n;
  logic            commit;

  // Writes are only accepted while idle; a clear sequence silently drops them.
  always_comb begin
    commit = regwrite && (state == IDLE) && (|wbe) && !(ZERO_REG && (wra == '0));
    merged = mem[wra];
    for (int i = 0; i < NB; i++) begin
      if (wbe[i]) merged[8*i +: 8] = wd[8*i +: 8];
    end
  end

  always_comb begin
    rd1_n = mem[rs1];
    rd2_n = mem[rs2];
    if (commit && (rs1 == wra)) rd1_n = merged;
    if (commit && (rs2 == wra)) rd2_n = merged;
    if (ZERO_REG && (rs1 == '0)) rd1_n = '0;
    if (ZERO_REG && (rs2 == '0)) rd2_n = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd1   <= '0;
      rd2   <= '0;
      busy  <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      rd1 <= rd1_n;
      rd2 <= rd2_n;
      case (state)
        IDLE: begin
          if (commit) mem[wra] <= merged;
          if (clr_req) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          mem[cnt] <= '0;
          cnt      <= cnt + 1'b1;
          if (&cnt) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
